opb_register_ppc2simulink_bank: RTL and testbench



---
 rtl/opb_pkg.sv | 24 ++
 rtl/opb_slave_decode.sv | 61 ++++++
 rtl/opb_register_ppc2simulink_bank.sv | 90 +++++++++
 tb/tb_opb_register_ppc2simulink_bank.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/opb_pkg.sv
// Shared OPB slave definitions: bus widths, transfer FSM states and the
// big-endian byte-enable merge used by register banks on this bus.
package opb_pkg;

    localparam int OPB_DWIDTH = 32;
    localparam int OPB_AWIDTH = 32;

    typedef enum logic {
        IDLE,
        ACK
    } opb_state_t;

    // be[0] covers the most significant byte (OPB big-endian lane order).
    function automatic logic [OPB_DWIDTH-1:0] be_merge(
        input logic [OPB_DWIDTH-1:0] old_val,
        input logic [OPB_DWIDTH-1:0] data,
        input logic [0:3]            be
    );
        logic [OPB_DWIDTH-1:0] mask;
        mask = {{8{be[0]}}, {8{be[1]}}, {8{be[2]}}, {8{be[3]}}};
        return (old_val & ~mask) | (data & mask);
    endfunction

endpackage

// File: rtl/opb_slave_decode.sv
// Address-window decode and IDLE/ACK handshake FSM for an OPB slave.
// req_rd/req_wr mark the cycle a transfer is accepted; ack follows one cycle later.
module opb_slave_decode
    import opb_pkg::*;
#(
    parameter int              AW        = OPB_AWIDTH,
    parameter logic [AW-1:0]   BASE_ADDR = '0,
    parameter logic [AW-1:0]   HIGH_ADDR = '1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] addr,
    input  logic          select,
    input  logic          rnw,
    output logic          req_rd,
    output logic          req_wr,
    output logic [AW-3:0] index,
    output logic          ack
);

    opb_state_t    state;
    logic          in_win;
    logic          req;
    logic [AW-1:0] offset;
    logic          unused_low;

    assign in_win     = (addr >= BASE_ADDR) && (addr <= HIGH_ADDR);
    assign offset     = addr - BASE_ADDR;
    assign index      = offset[AW-1:2];
    assign unused_low = ^offset[1:0];

    // Only IDLE accepts, so a held select yields one ack per two cycles.
    assign req    = select && in_win && (state == IDLE);
    assign req_rd = req && rnw;
    assign req_wr = req && !rnw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ack   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        state <= ACK;
                        ack   <= 1'b1;
                    end
                end
                ACK: begin
                    state <= IDLE;
                    ack   <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    ack   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/opb_register_ppc2simulink_bank.sv
// OPB-writable control register bank: PPC writes land on user_data_out with a
// one-cycle user_update strobe per register; every register reads back.
module opb_register_ppc2simulink_bank
    import opb_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h01090000,
    parameter logic [31:0] C_HIGHADDR   = 32'h010900FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter int          NUM_REGS     = 4,
    parameter logic [31:0] INIT_VALUE   = 32'h00000000
) (
    input  logic                           OPB_Clk,
    input  logic                           OPB_Rst_n,
    input  logic [0:C_OPB_AWIDTH-1]        OPB_ABus,
    input  logic [0:3]                     OPB_BE,
    input  logic [0:OPB_DWIDTH-1]          OPB_DBus,
    input  logic                           OPB_RNW,
    input  logic                           OPB_select,
    input  logic                           OPB_seqAddr,
    output logic [0:OPB_DWIDTH-1]          Sl_DBus,
    output logic                           Sl_errAck,
    output logic                           Sl_retry,
    output logic                           Sl_toutSup,
    output logic                           Sl_xferAck,
    output logic [NUM_REGS*32-1:0]         user_data_out,
    output logic [NUM_REGS-1:0]            user_update
);

    localparam int IXW = C_OPB_AWIDTH - 2;
    localparam int IW  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    if (C_OPB_DWIDTH != OPB_DWIDTH) begin : g_bad_dwidth
        $error("opb_register_ppc2simulink_bank supports only a 32-bit OPB data bus");
    end

    logic                               req_rd;
    logic                               req_wr;
    logic [IXW-1:0]                     index;
    logic                               in_range;
    logic [IW-1:0]                      reg_idx;
    logic [NUM_REGS-1:0][OPB_DWIDTH-1:0] regs_q;
    logic                               unused_seq;

    assign unused_seq = OPB_seqAddr;

    opb_slave_decode #(
        .AW        (C_OPB_AWIDTH),
        .BASE_ADDR (C_BASEADDR[C_OPB_AWIDTH-1:0]),
        .HIGH_ADDR (C_HIGHADDR[C_OPB_AWIDTH-1:0])
    ) u_decode (
        .clk    (OPB_Clk),
        .rst_n  (OPB_Rst_n),
        .addr   (OPB_ABus),
        .select (OPB_select),
        .rnw    (OPB_RNW),
        .req_rd (req_rd),
        .req_wr (req_wr),
        .index  (index),
        .ack    (Sl_xferAck)
    );

    // In-window words past the last register ack but never touch the array.
    assign in_range = index < IXW'(NUM_REGS);
    assign reg_idx  = index[IW-1:0];

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            regs_q      <= {NUM_REGS{INIT_VALUE}};
            user_update <= '0;
            Sl_DBus     <= '0;
        end else begin
            user_update <= '0;
            Sl_DBus     <= '0;
            if (req_wr && in_range) begin
                regs_q[reg_idx]      <= be_merge(regs_q[reg_idx], OPB_DBus, OPB_BE);
                user_update[reg_idx] <= 1'b1;
            end
            if (req_rd && in_range) begin
                Sl_DBus <= regs_q[reg_idx];
            end
        end
    end

    assign user_data_out = regs_q;
    assign Sl_errAck     = 1'b0;
    assign Sl_retry      = 1'b0;
    assign Sl_toutSup    = 1'b0;

endmodule

// File: tb/tb_opb_register_ppc2simulink_bank.sv
// Directed-vector bench for opb_register_ppc2simulink_bank with hand-computed expectations.
module tb_opb_register_ppc2simulink_bank;

    localparam logic [31:0] BASE = 32'h01090000;
    localparam logic [31:0] HIGH = 32'h010900FF;
    localparam logic [31:0] INIT = 32'hA5A5A5A5;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [0:31]  abus;
    logic [0:3]   be;
    logic [0:31]  dbus;
    logic         rnw;
    logic         sel;
    logic         seq;
    logic [0:31]  sl_dbus;
    logic         sl_err, sl_retry, sl_tout, sl_ack;
    logic [127:0] udata;
    logic [3:0]   uupd;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    logic [31:0] model [4];

    opb_register_ppc2simulink_bank #(
        .C_BASEADDR   (BASE),
        .C_HIGHADDR   (HIGH),
        .C_OPB_AWIDTH (32),
        .C_OPB_DWIDTH (32),
        .NUM_REGS     (4),
        .INIT_VALUE   (INIT)
    ) dut (
        .OPB_Clk       (clk),
        .OPB_Rst_n     (rst_n),
        .OPB_ABus      (abus),
        .OPB_BE        (be),
        .OPB_DBus      (dbus),
        .OPB_RNW       (rnw),
        .OPB_select    (sel),
        .OPB_seqAddr   (seq),
        .Sl_DBus       (sl_dbus),
        .Sl_errAck     (sl_err),
        .Sl_retry      (sl_retry),
        .Sl_toutSup    (sl_tout),
        .Sl_xferAck    (sl_ack),
        .user_data_out (udata),
        .user_update   (uupd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] model_flat();
        return {model[3], model[2], model[1], model[0]};
    endfunction

    function automatic logic [31:0] ref_merge(input logic [31:0] o, input logic [31:0] d,
                                              input logic [0:3] b);
        logic [31:0] r;
        r = o;
        if (b[0]) r[31:24] = d[31:24];
        if (b[1]) r[23:16] = d[23:16];
        if (b[2]) r[15:8]  = d[15:8];
        if (b[3]) r[7:0]   = d[7:0];
        return r;
    endfunction

    // One beat: request, sample the ack cycle, drop select, return in the next idle cycle.
    task automatic xfer(input logic r, input logic [31:0] a, input logic [0:3] b,
                        input logic [31:0] d, output logic ack, output logic [31:0] rd,
                        output logic [3:0] up, output logic [127:0] ud);
        sel = 1'b1; rnw = r; abus = a; be = b; dbus = d;
        @(posedge clk); #1;
        ack = sl_ack; rd = sl_dbus; up = uupd; ud = udata;
        sel = 1'b0; rnw = 1'b1;
        @(posedge clk); #1;
    endtask

    logic         a;
    logic [31:0]  rd;
    logic [3:0]   up;
    logic [127:0] ud;
    int unsigned  acks, bad_rd, nz_idle, side;
    logic [5:0]   pattern;

    initial begin
        sel = 1'b0; rnw = 1'b1; abus = '0; be = '0; dbus = '0; seq = 1'b0;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) model[i] = INIT;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", sl_ack, 1'b0);
        chk("rst_upd", uupd, 4'b0000);
        chk("rst_dbus", sl_dbus, 32'h0);
        chk("rst_regs", udata, {4{INIT}});
        rst_n = 1'b1;

        xfer(1'b0, BASE + 4, 4'b1111, 32'h12345678, a, rd, up, ud);
        model[1] = 32'h12345678;
        chk("wr1_ack", a, 1'b1);
        chk("wr1_upd", up, 4'b0010);
        chk("wr1_word", ud[63:32], 32'h12345678);
        chk("wr1_upd_clr", uupd, 4'b0000);
        chk("wr1_regs", udata, model_flat());

        xfer(1'b1, BASE + 4, 4'b1111, 32'h0, a, rd, up, ud);
        chk("rd1_ack", a, 1'b1);
        chk("rd1_data", rd, 32'h12345678);
        chk("rd1_upd", up, 4'b0000);

        // Reset during the ack cycle of a write.
        sel = 1'b1; rnw = 1'b0; abus = BASE; be = 4'b1111; dbus = 32'hDEADBEEF;
        @(posedge clk); #1;
        chk("mid_ack_pre", sl_ack, 1'b1);
        rst_n = 1'b0; sel = 1'b0; rnw = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) model[i] = INIT;
        chk("mid_rst_ack", sl_ack, 1'b0);
        chk("mid_rst_upd", uupd, 4'b0000);
        chk("mid_rst_dbus", sl_dbus, 32'h0);
        chk("mid_rst_regs", udata, {4{INIT}});
        @(posedge clk); #1;
        rst_n = 1'b1;

        xfer(1'b0, BASE, 4'b1111, 32'hFFFFFFFF, a, rd, up, ud);
        model[0] = 32'hFFFFFFFF;
        chk("wr0_full", udata, model_flat());
        xfer(1'b0, BASE, 4'b0101, 32'h00000000, a, rd, up, ud);
        model[0] = ref_merge(model[0], 32'h0, 4'b0101);
        chk("be0101_ack", a, 1'b1);
        chk("be0101_upd", up, 4'b0001);
        chk("be0101_val", udata[31:0], 32'hFF00FF00);
        chk("be0101_regs", udata, model_flat());

        xfer(1'b0, BASE + 8, 4'b0000, 32'h00000000, a, rd, up, ud);
        chk("be0000_ack", a, 1'b1);
        chk("be0000_upd", up, 4'b0100);
        chk("be0000_regs", udata, model_flat());

        xfer(1'b1, BASE + 16, 4'b1111, 32'h0, a, rd, up, ud);
        chk("oor_rd_ack", a, 1'b1);
        chk("oor_rd_data", rd, 32'h0);
        xfer(1'b0, BASE + 16, 4'b1111, 32'h11111111, a, rd, up, ud);
        chk("oor_wr_ack", a, 1'b1);
        chk("oor_wr_upd", up, 4'b0000);
        chk("oor_wr_regs", udata, model_flat());
        xfer(1'b1, HIGH, 4'b1111, 32'h0, a, rd, up, ud);
        chk("top_word_ack", a, 1'b1);
        chk("top_word_data", rd, 32'h0);

        // Outside the window: never acked, nothing written.
        acks = 0;
        sel = 1'b1; rnw = 1'b0; abus = HIGH + 4; be = 4'b1111; dbus = 32'h55555555;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (sl_ack) acks++;
        end
        abus = BASE - 4;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (sl_ack) acks++;
        end
        sel = 1'b0; rnw = 1'b1;
        chk("outside_acks", acks, 0);
        chk("outside_regs", udata, model_flat());

        // Held select on a read: ack every other cycle.
        acks = 0; bad_rd = 0; nz_idle = 0; side = 0; pattern = '0;
        sel = 1'b1; rnw = 1'b1; abus = BASE + 8;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            pattern = {pattern[4:0], sl_ack};
            if (sl_ack) begin
                acks++;
                if (sl_dbus !== model[2]) bad_rd++;
            end else if (sl_dbus !== 32'h0) begin
                nz_idle++;
            end
            if (sl_err || sl_retry || sl_tout) side++;
        end
        sel = 1'b0;
        @(posedge clk); #1;
        chk("held_pattern", pattern, 6'b101010);
        chk("held_acks", acks, 3);
        chk("held_rd_data", bad_rd, 0);
        chk("held_idle_dbus", nz_idle, 0);
        chk("held_side_sigs", side, 0);
        chk("held_after_drop", sl_ack, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
